// File: rtl/swap_sched.sv
// Round-robin shared swap engine over a small register file.
// Each accepted swap runs IDLE -> LOAD -> WRITE -> DONE; both entries update on one edge.
module swap_sched #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int IDX_W  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic [IDX_W-1:0]  req0_idx_a,
  input  logic [IDX_W-1:0]  req0_idx_b,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [IDX_W-1:0]  req1_idx_a,
  input  logic [IDX_W-1:0]  req1_idx_b,
  output logic              req1_ready,
  output logic              done_valid,
  output logic              done_id,
  output logic              busy,
  input  logic              init_we,
  input  logic [IDX_W-1:0]  init_idx,
  input  logic [DATA_W-1:0] init_data,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_data
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [IDX_W:0] DEPTH_L = (IDX_W + 1)'(DEPTH);

  logic [1:0]        state;
  logic              ptr;
  logic              owner;
  logic [IDX_W-1:0]  ia;
  logic [IDX_W-1:0]  ib;
  logic [DATA_W-1:0] ta;
  logic [DATA_W-1:0] tb;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              idle;
  logic              grant0;
  logic              grant1;
  logic              accept_ok;
  logic              handshake;
  logic              swap_en;
  logic              init_en;
  logic [DATA_W-1:0] rd_a;
  logic [DATA_W-1:0] rd_b;

  function automatic logic in_range(input logic [IDX_W-1:0] idx);
    return ({1'b0, idx} < DEPTH_L);
  endfunction

  assign idle = (state == S_IDLE);

  // A lone requester wins outright; the pointer only breaks ties.
  assign grant0    = req0_valid & (~req1_valid | ~ptr);
  assign grant1    = req1_valid & (~req0_valid | ptr);
  assign accept_ok = idle & ~init_we & rst_n;
  assign req0_ready = accept_ok & grant0;
  assign req1_ready = accept_ok & grant1;
  assign handshake  = req0_ready | req1_ready;

  assign busy       = ~idle;
  assign done_valid = (state == S_DONE);
  assign done_id    = (state == S_DONE) & owner;

  // A swap touching any out-of-range entry leaves the whole file untouched.
  assign swap_en = (state == S_WRITE) & in_range(ia) & in_range(ib);
  assign init_en = idle & init_we;

  always_comb begin
    rd_data = '0;
    rd_a    = '0;
    rd_b    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rd_idx == IDX_W'(i)) rd_data = mem[i];
      if (ia == IDX_W'(i))     rd_a    = mem[i];
      if (ib == IDX_W'(i))     rd_b    = mem[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      ptr   <= 1'b0;
      owner <= 1'b0;
      ia    <= '0;
      ib    <= '0;
      ta    <= '0;
      tb    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (handshake) begin
            ia    <= req1_ready ? req1_idx_a : req0_idx_a;
            ib    <= req1_ready ? req1_idx_b : req0_idx_b;
            owner <= req1_ready;
            ptr   <= ~req1_ready;
            state <= S_LOAD;
          end
        end
        S_LOAD: begin
          ta    <= rd_a;
          tb    <= rd_b;
          state <= S_WRITE;
        end
        S_WRITE: state <= S_DONE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (init_en && init_idx == IDX_W'(i)) begin
          mem[i] <= init_data;
        end else if (swap_en && ia == IDX_W'(i)) begin
          mem[i] <= tb;
        end else if (swap_en && ib == IDX_W'(i)) begin
          mem[i] <= ta;
        end
      end
    end
  end

endmodule

// File: tb/tb_swap_sched.sv
// Self-checking bench for swap_sched: vector table of arbitration scenarios,
// hand-written corner sequences, and a done_id scoreboard.
module tb_swap_sched;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 8;
  localparam int IDX_W  = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req0_valid, req1_valid;
  logic [IDX_W-1:0]  req0_idx_a, req0_idx_b, req1_idx_a, req1_idx_b;
  logic              req0_ready, req1_ready;
  logic              done_valid, done_id, busy;
  logic              init_we;
  logic [IDX_W-1:0]  init_idx;
  logic [DATA_W-1:0] init_data;
  logic [IDX_W-1:0]  rd_idx;
  logic [DATA_W-1:0] rd_data;

  always #5 clk = ~clk;

  swap_sched #(.DATA_W(DATA_W), .DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_idx_a(req0_idx_a), .req0_idx_b(req0_idx_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_idx_a(req1_idx_a), .req1_idx_b(req1_idx_b), .req1_ready(req1_ready),
    .done_valid(done_valid), .done_id(done_id), .busy(busy),
    .init_we(init_we), .init_idx(init_idx), .init_data(init_data),
    .rd_idx(rd_idx), .rd_data(rd_data)
  );

  int checks = 0;
  int errors = 0;
  int exp_done[$];
  int pushed = 0;
  int done_seen = 0;
  int grant_log[$];
  int model [DEPTH];

  typedef struct {
    string            name;
    int               n0;
    logic [IDX_W-1:0] a0, b0;
    int               n1;
    logic [IDX_W-1:0] a1, b1;
    int               ng;
    int               g0, g1, g2;
  } vec_t;
  vec_t vecs[5];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest accepted owner.
  initial begin
    forever begin
      @(negedge clk);
      if (done_valid) begin
        done_seen++;
        if (exp_done.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL done_unexpected: got done_id %0d expected no done", done_id);
        end else begin
          check("done_id", int'(done_id), exp_done.pop_front());
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic expect_done(input int id);
    exp_done.push_back(id);
    pushed++;
  endtask

  task automatic model_swap(input logic [IDX_W-1:0] a, input logic [IDX_W-1:0] b);
    int t;
    if (int'(a) < DEPTH && int'(b) < DEPTH) begin
      t = model[a];
      model[a] = model[b];
      model[b] = t;
    end
  endtask

  task automatic idle_inputs();
    req0_valid = 0; req1_valid = 0;
    req0_idx_a = '0; req0_idx_b = '0; req1_idx_a = '0; req1_idx_b = '0;
    init_we = 0; init_idx = '0; init_data = '0; rd_idx = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < DEPTH; i++) model[i] = 0;
  endtask

  task automatic preload();
    int pre [DEPTH] = '{123, 200, 10, 20, 30, 40, 77, 55};
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      init_we = 1; init_idx = IDX_W'(i); init_data = DATA_W'(pre[i]);
      model[i] = pre[i];
    end
    @(negedge clk);
    init_we = 0;
  endtask

  task automatic check_mem(input string tag);
    for (int i = 0; i < DEPTH; i++) begin
      rd_idx = IDX_W'(i);
      #1;
      check($sformatf("%s_rd%0d", tag, i), int'(rd_data), model[i]);
    end
  endtask

  task automatic wait_idle(input string tag);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (exp_done.size() == 0 && !busy) break;
    end
    check({tag, "_drain"}, exp_done.size(), 0);
  endtask

  task automatic serve(input int n0, input logic [IDX_W-1:0] a0, input logic [IDX_W-1:0] b0,
                       input int n1, input logic [IDX_W-1:0] a1, input logic [IDX_W-1:0] b1);
    int c0 = n0;
    int c1 = n1;
    grant_log.delete();
    for (int cyc = 0; cyc < 100 && (c0 > 0 || c1 > 0); cyc++) begin
      @(negedge clk);
      req0_valid = (c0 > 0); req0_idx_a = a0; req0_idx_b = b0;
      req1_valid = (c1 > 0); req1_idx_a = a1; req1_idx_b = b1;
      #1;
      check("ready_onehot", int'(req0_ready & req1_ready), 0);
      if (req0_ready) begin c0--; grant_log.push_back(0); expect_done(0); model_swap(a0, b0); end
      if (req1_ready) begin c1--; grant_log.push_back(1); expect_done(1); model_swap(a1, b1); end
    end
    @(negedge clk);
    req0_valid = 0; req1_valid = 0;
    check("serve_timeout", c0 + c1, 0);
  endtask

  initial begin
    int old1, exp_g[3];
    rst_n = 1;
    idle_inputs();

    vecs[0] = '{"basic", 1, 4'd0, 4'd1, 0, 4'd0, 4'd0, 1, 0, 0, 0};
    vecs[1] = '{"arb",   1, 4'd2, 4'd3, 1, 4'd4, 4'd5, 2, 0, 1, 0};
    vecs[2] = '{"fair",  2, 4'd6, 4'd7, 1, 4'd0, 4'd2, 3, 0, 1, 0};
    vecs[3] = '{"same",  0, 4'd0, 4'd0, 1, 4'd6, 4'd6, 1, 1, 0, 0};
    vecs[4] = '{"oor",   1, 4'd0, 4'd9, 0, 4'd0, 4'd0, 1, 0, 0, 0};

    // Reset state, including ready held low while valids are high in reset.
    @(negedge clk);
    rst_n = 0;
    req0_valid = 1; req1_valid = 1;
    #1;
    check("rst_ready0", int'(req0_ready), 0);
    check("rst_ready1", int'(req1_ready), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done_valid), 0);
    check("rst_done_id", int'(done_id), 0);
    do_reset();
    check_mem("rst");

    for (int v = 0; v < 5; v++) begin
      do_reset();
      preload();
      serve(vecs[v].n0, vecs[v].a0, vecs[v].b0, vecs[v].n1, vecs[v].a1, vecs[v].b1);
      wait_idle(vecs[v].name);
      exp_g = '{vecs[v].g0, vecs[v].g1, vecs[v].g2};
      check({vecs[v].name, "_ngrants"}, grant_log.size(), vecs[v].ng);
      for (int k = 0; k < vecs[v].ng && k < grant_log.size(); k++)
        check($sformatf("%s_grant%0d", vecs[v].name, k), grant_log[k], exp_g[k]);
      check_mem(vecs[v].name);
    end

    // Latency: contents change and done pulses two edges after the handshake edge;
    // a new request is accepted on the cycle right after DONE.
    do_reset();
    preload();
    @(negedge clk);
    req0_valid = 1; req0_idx_a = 4'd1; req0_idx_b = 4'd2;
    #1;
    check("lat_ready0", int'(req0_ready), 1);
    old1 = model[1];
    expect_done(0); model_swap(4'd1, 4'd2);
    @(negedge clk);
    req0_valid = 0; rd_idx = 4'd1;
    #1;
    check("lat_load_busy", int'(busy), 1);
    check("lat_load_done", int'(done_valid), 0);
    @(negedge clk);
    #1;
    check("lat_write_old", int'(rd_data), old1);
    check("lat_write_done", int'(done_valid), 0);
    @(negedge clk);
    #1;
    check("lat_done_pulse", int'(done_valid), 1);
    check("lat_done_new", int'(rd_data), model[1]);
    @(negedge clk);
    req1_valid = 1; req1_idx_a = 4'd3; req1_idx_b = 4'd4;
    #1;
    check("lat_after_done", int'(done_valid), 0);
    check("lat_after_busy", int'(busy), 0);
    check("lat_b2b_ready1", int'(req1_ready), 1);
    expect_done(1); model_swap(4'd3, 4'd4);
    @(negedge clk);
    req1_valid = 0;
    wait_idle("lat");
    check_mem("lat");

    // Direct write during WRITE is dropped.
    @(negedge clk);
    req0_valid = 1; req0_idx_a = 4'd2; req0_idx_b = 4'd3;
    #1;
    check("initw_ready0", int'(req0_ready), 1);
    expect_done(0); model_swap(4'd2, 4'd3);
    @(negedge clk);
    req0_valid = 0;
    @(negedge clk);
    init_we = 1; init_idx = 4'd1; init_data = 8'd99;
    @(negedge clk);
    init_we = 0;
    wait_idle("initw");
    check_mem("initw");

    // Direct write in IDLE beats a pending request for one cycle.
    @(negedge clk);
    init_we = 1; init_idx = 4'd4; init_data = 8'd66;
    req1_valid = 1; req1_idx_a = 4'd4; req1_idx_b = 4'd5;
    #1;
    check("initi_ready1_blocked", int'(req1_ready), 0);
    model[4] = 66;
    @(negedge clk);
    init_we = 0;
    #1;
    check("initi_ready1_next", int'(req1_ready), 1);
    expect_done(1); model_swap(4'd4, 4'd5);
    @(negedge clk);
    req1_valid = 0;
    wait_idle("initi");
    check_mem("initi");

    // Out-of-range reads return zero.
    rd_idx = 4'd9;
    #1;
    check("oor_read9", int'(rd_data), 0);
    rd_idx = 4'd15;
    #1;
    check("oor_read15", int'(rd_data), 0);

    // Reset during LOAD aborts the swap and returns the pointer to requester 0.
    do_reset();
    preload();
    @(negedge clk);
    req0_valid = 1; req0_idx_a = 4'd0; req0_idx_b = 4'd1;
    #1;
    check("mid_ready0", int'(req0_ready), 1);
    @(negedge clk);
    check("mid_in_load", int'(busy), 1);
    rst_n = 0;
    req1_valid = 1; req1_idx_a = 4'd2; req1_idx_b = 4'd3;
    #1;
    check("mid_busy", int'(busy), 0);
    check("mid_done", int'(done_valid), 0);
    check("mid_ready0_rst", int'(req0_ready), 0);
    for (int i = 0; i < DEPTH; i++) model[i] = 0;
    check_mem("mid");
    repeat (3) @(negedge clk);
    rst_n = 1;
    #1;
    check("mid_ptr_ready0", int'(req0_ready), 1);
    check("mid_ptr_ready1", int'(req1_ready), 0);
    expect_done(0); model_swap(4'd0, 4'd1);
    @(negedge clk);
    req0_valid = 0; req1_valid = 0;
    wait_idle("mid");
    check_mem("mid_end");

    repeat (2) @(negedge clk);
    check("done_count", done_seen, pushed);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/swap_sched.md
Name: swap_sched

Overview:
- Controller that owns a small register file of DATA_W-bit values and executes "swap entry A with entry B" operations on it.
- Shares the swap datapath between two requesters through a round-robin arbiter.
- Sequences each swap as a fixed capture/write-back pipeline, so both entries update on the same clock edge.
- Sits between software-facing request agents and the value store; a side port loads and reads entries for initialisation and checking.

Parameters:
- DATA_W, 8, width of each stored value.
- DEPTH, 8, number of entries in the register file.
- IDX_W, 3, width of entry indices; DEPTH <= 2**IDX_W.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  requester 0 has a swap pending.
- req0_idx_a  in  IDX_W  requester 0 first entry index.
- req0_idx_b  in  IDX_W  requester 0 second entry index.
- req0_ready  out  1  requester 0 swap accepted this cycle.
- req1_valid  in  1  requester 1 has a swap pending.
- req1_idx_a  in  IDX_W  requester 1 first entry index.
- req1_idx_b  in  IDX_W  requester 1 second entry index.
- req1_ready  out  1  requester 1 swap accepted this cycle.
- done_valid  out  1  one-cycle pulse when a swap completes.
- done_id  out  1  requester that owns the completing swap.
- busy  out  1  high whenever the FSM is not in IDLE.
- init_we  in  1  direct write strobe.
- init_idx  in  IDX_W  direct write index.
- init_data  in  DATA_W  direct write data.
- rd_idx  in  IDX_W  read index.
- rd_data  out  DATA_W  combinational read of entry rd_idx.

Behaviour:
- Reset (rst_n low, asynchronous):
  - all entries = 0; FSM = IDLE; RR pointer = requester 0.
  - done_valid = 0, done_id = 0, busy = 0, both ready = 0.
  - Capture registers ta, tb, ia, ib, owner = 0.
- FSM states: IDLE -> LOAD -> WRITE -> DONE -> IDLE, fixed, no stalls.
- IDLE:
  - Grant is combinational from valid and the RR pointer; ready is asserted only to the granted requester, only in IDLE, and only when init_we = 0.
  - Handshake completes when valid & ready. On that edge: ia/ib/owner latch the granted request, the RR pointer moves to the other requester, and the FSM goes to LOAD.
  - RR rule: if only one requester is valid, it is granted regardless of the pointer. If both are valid, the pointer's requester is granted.
  - The pointer changes only on an accepted handshake.
- LOAD: ta <= mem[ia], tb <= mem[ib]; go to WRITE.
- WRITE: mem[ia] <= tb and mem[ib] <= ta on the same edge (non-blocking semantics, no intermediate state visible); go to DONE.
- DONE: done_valid = 1, done_id = owner for exactly this cycle; go to IDLE. A new request can be accepted on the cycle after DONE.
- Latency: handshake at edge N; contents change at edge N+2; done_valid is high during cycle N+2..N+3; throughput is one swap per 4 cycles.
- ia == ib: the full sequence runs, the entry is unchanged, and done still pulses.
- init_we:
  - Honoured only in IDLE; it has priority over requests, which are not granted that cycle.
  - Ignored (write dropped) in LOAD/WRITE/DONE.
- Out-of-range index (>= DEPTH): reads return 0, writes are dropped, and the swap sequence and done pulse still occur.
- rd_data reflects register contents at all times; new values are visible the cycle after WRITE.
- Requesters must hold valid and indices stable until ready. The block does not check for valid dropping without ready.
- Reset asserted mid-swap aborts it: no done pulse, contents cleared, pointer back to requester 0.

Test Plan:
- Basic swap: init entry0=123, entry1=200; req0 swap(0,1) -> req0_ready one cycle; done_valid=1, done_id=0 three cycles later; rd 0=200, rd 1=123.
- Arbitration: both valid from IDLE after reset, req0 (2,3), req1 (4,5), entries 2..5 = 10,20,30,40 -> req0 served first, then req1 four cycles later; final 20,10,40,30; done_id sequence 0,1.
- Fairness: req0 held valid continuously, req1 asserted once -> grants alternate 0,1,0 with no back-to-back grant to req0 while req1 waits.
- Degenerate swaps: swap(6,6) with entry6=77 -> done pulses, entry6=77. swap(0,9) with DEPTH=8, IDX_W=4 -> entry0 unchanged, done pulses.
- Init collisions: init_we to entry1 during WRITE -> dropped. init_we in IDLE concurrent with req1_valid -> write lands, req1_ready=0 that cycle, granted next cycle.
- Mid-op reset: assert rst_n=0 during LOAD of swap(0,1) -> no done_valid, all entries 0, busy=0; after release, req1 granted first when both valid? No: req0 (pointer reset).
